alu_muldiv_control: RTL and testbench

Successor ALU control for the single-cycle RISC-V core.
- Decodes the full 7-bit funct7, ALU_Op and funct3 into the 4-bit ALU operation code.
- Adds an iterative RV32M multiply/divide engine whose results feed the writeback mux.
- Stalls the PC/register-file write while an M-extension instruction iterates.
- Sits between the main control unit, register file read ports and the writeback mux.

---
 rtl/alu_muldiv_control.sv | 187 ++++++++++++++++++
 tb/tb_alu_muldiv_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_control.sv
// ALU opcode decode plus an iterative RV32M multiply/divide engine.
// The engine holds stall_o while it iterates; md_done_o pulses when md_result_o is valid.
module alu_muldiv_control #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic [6:0]              funct7_i,
  input  logic [2:0]              ALU_Op_i,
  input  logic [2:0]              funct3_i,
  input  logic [DATA_WIDTH-1:0]   rs1_data_i,
  input  logic [DATA_WIDTH-1:0]   rs2_data_i,
  output logic [ALU_OP_WIDTH-1:0] ALU_Operation_o,
  output logic                    md_sel_o,
  output logic                    stall_o,
  output logic                    md_done_o,
  output logic [DATA_WIDTH-1:0]   md_result_o
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opa_q, opa_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [1:0]           f3_q, f3_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [W-1:0]         result_q, result_d;

  logic [3:0] alu_op;
  logic       md_op;
  logic       accept;
  logic       a_signed, b_signed, sa_in, sb_in;
  logic [W-1:0] mag_a, mag_b;
  logic       div_zero, div_ovf, last;
  logic [W:0]     mul_sum, div_trial;
  logic [2*W-1:0] mul_step, mul_prod, div_step;
  logic [W-1:0]   mul_final, quo, rem, quo_s, rem_s, div_final;

  always_comb begin
    alu_op = 4'b0000;
    unique case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == 7'b0000000) begin
          unique case (funct3_i)
            3'b110:  alu_op = 4'b1001;
            3'b001:  alu_op = 4'b1100;
            3'b101:  alu_op = 4'b1101;
            default: alu_op = 4'b0000;
          endcase
        end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
          alu_op = 4'b0001;
        end
      end
      3'b001: begin
        if (funct3_i == 3'b110) alu_op = 4'b1001;
        else if (funct7_i == 7'b0000000 && funct3_i == 3'b001) alu_op = 4'b1100;
        else if (funct7_i == 7'b0000000 && funct3_i == 3'b101) alu_op = 4'b1101;
      end
      3'b010:  alu_op = 4'b1000;
      default: alu_op = 4'b0000;
    endcase
  end

  assign md_op           = (ALU_Op_i == 3'b000) && (funct7_i == 7'b0000001);
  assign md_sel_o        = md_op;
  assign ALU_Operation_o = md_op ? '0 : ALU_OP_WIDTH'(alu_op);
  assign accept          = (state_q == S_IDLE) && valid_i && md_op;

  // Multiplies: only MULHU is unsigned in rs1; MULHSU/MULHU unsigned in rs2.
  // Divides: the odd funct3 encodings (DIVU/REMU) are unsigned.
  assign a_signed = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign b_signed = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
  assign sa_in    = a_signed && rs1_data_i[W-1];
  assign sb_in    = b_signed && rs2_data_i[W-1];
  assign mag_a    = sa_in ? -rs1_data_i : rs1_data_i;
  assign mag_b    = sb_in ? -rs2_data_i : rs2_data_i;
  assign div_zero = (rs2_data_i == '0);
  assign div_ovf  = !funct3_i[0] && (rs1_data_i == {1'b1, {(W-1){1'b0}}}) && (rs2_data_i == '1);
  assign last     = (cnt_q == CNT_WIDTH'(W - 1));

  // acc holds {high, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opa_q : {W{1'b0}})};
  assign mul_step  = {mul_sum, acc_q[W-1:1]};
  assign mul_prod  = (sa_q ^ sb_q) ? -mul_step : mul_step;
  assign mul_final = (f3_q == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];

  assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opb_q};
  assign div_step  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                  : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
  assign quo       = div_step[W-1:0];
  assign rem       = div_step[2*W-1:W];
  assign quo_s     = (sa_q ^ sb_q) ? -quo : quo;
  assign rem_s     = sa_q ? -rem : rem;
  assign div_final = f3_q[1] ? rem_s : quo_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d  = funct3_i[1:0];
          sa_d  = sa_in;
          sb_d  = sb_in;
          opa_d = mag_a;
          opb_d = mag_b;
          cnt_d = '0;
          if (!funct3_i[2]) begin
            acc_d   = {{W{1'b0}}, mag_b};
            state_d = S_MUL;
          end else if (div_zero) begin
            result_d = funct3_i[1] ? rs1_data_i : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3_i[1] ? '0 : rs1_data_i;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{W{1'b0}}, mag_a};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (last) begin
          result_d = mul_final;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_step;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (last) begin
          result_d = div_final;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign stall_o     = accept || (state_q == S_MUL) || (state_q == S_DIV);
  assign md_done_o   = (state_q == S_DONE);
  assign md_result_o = result_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Directed bench for alu_muldiv_control: decode sweep, M-op results, latency, corner cases, reset abort.
module tb_alu_muldiv_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [6:0]  funct7_i;
  logic [2:0]  ALU_Op_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [3:0]  ALU_Operation_o;
  logic        md_sel_o;
  logic        stall_o;
  logic        md_done_o;
  logic [31:0] md_result_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_control #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct7_i(funct7_i),
    .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .ALU_Operation_o(ALU_Operation_o), .md_sel_o(md_sel_o),
    .stall_o(stall_o), .md_done_o(md_done_o), .md_result_o(md_result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dec(input string tag, input logic [6:0] f7, input logic [2:0] op,
                     input logic [2:0] f3, input logic [3:0] exp_op, input logic exp_sel);
    @(negedge clk);
    valid_i = 1'b0; funct7_i = f7; ALU_Op_i = op; funct3_i = f3;
    #1;
    chk({tag, " op"}, 32'(ALU_Operation_o), 32'(exp_op));
    chk({tag, " sel"}, 32'(md_sel_o), 32'(exp_sel));
  endtask

  // Launch with a one-cycle valid pulse, count stall cycles until md_done_o, check result.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_stall);
    int  stalls;
    bit  seen;
    @(negedge clk);
    valid_i = 1'b1; funct7_i = 7'b0000001; ALU_Op_i = 3'b000; funct3_i = f3;
    rs1_data_i = a; rs2_data_i = b;
    #1;
    stalls = stall_o ? 1 : 0;
    seen   = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (md_done_o) seen = 1'b1;
      else begin
        if (stall_o) stalls++;
        @(negedge clk);
      end
    end
    chk({tag, " done"}, 32'(seen), 32'd1);
    chk({tag, " stalls"}, 32'(stalls), 32'(exp_stall));
    chk({tag, " result"}, md_result_o, exp_r);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(md_done_o), 32'd0);
    chk({tag, " hold"}, md_result_o, exp_r);
  endtask

  initial begin
    int  stalls;
    bit  seen;
    bit  done_seen;
    reset = 1'b1; valid_i = 1'b0; funct7_i = '0; ALU_Op_i = '0; funct3_i = '0;
    rs1_data_i = '0; rs2_data_i = '0;
    #12;
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset done", 32'(md_done_o), 32'd0);
    chk("reset result", md_result_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    dec("ADD",    7'b0000000, 3'b000, 3'b000, 4'b0000, 1'b0);
    dec("SUB",    7'b0100000, 3'b000, 3'b000, 4'b0001, 1'b0);
    dec("OR",     7'b0000000, 3'b000, 3'b110, 4'b1001, 1'b0);
    dec("SLL",    7'b0000000, 3'b000, 3'b001, 4'b1100, 1'b0);
    dec("SRL",    7'b0000000, 3'b000, 3'b101, 4'b1101, 1'b0);
    dec("ADDI",   7'b1010101, 3'b001, 3'b000, 4'b0000, 1'b0);
    dec("ORI",    7'b0110011, 3'b001, 3'b110, 4'b1001, 1'b0);
    dec("SLLI",   7'b0000000, 3'b001, 3'b001, 4'b1100, 1'b0);
    dec("SRLI",   7'b0000000, 3'b001, 3'b101, 4'b1101, 1'b0);
    dec("SRLI f7",7'b0100000, 3'b001, 3'b101, 4'b0000, 1'b0);
    dec("LUI",    7'b1111111, 3'b010, 3'b011, 4'b1000, 1'b0);
    dec("Mop",    7'b0000001, 3'b000, 3'b001, 4'b0000, 1'b1);
    dec("unmap",  7'b0100000, 3'b000, 3'b110, 4'b0000, 1'b0);
    dec("unmapop",7'b0000000, 3'b101, 3'b110, 4'b0000, 1'b0);
    chk("no launch idle", 32'(stall_o), 32'd0);

    run_md("MUL 7x-3",  3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_md("MULHU max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("MULH -1x-1",3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_md("MULHSU",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_md("DIV -7/2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_md("REM -7/2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_md("DIVU 100/7",3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_md("REMU 100/7",3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_md("DIV 5/0",   3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_md("REM 5/0",   3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_md("DIV ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("REM ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // DIVU 100/7 with operands changed mid-op and valid held through DONE.
    @(negedge clk);
    valid_i = 1'b1; funct7_i = 7'b0000001; ALU_Op_i = 3'b000; funct3_i = 3'b101;
    rs1_data_i = 32'd100; rs2_data_i = 32'd7;
    #1;
    stalls = stall_o ? 1 : 0;
    seen   = 1'b0;
    @(negedge clk);
    for (int i = 1; i < 100 && !seen; i++) begin
      if (i == 10) begin rs1_data_i = 32'd999; rs2_data_i = 32'd3; end
      if (md_done_o) seen = 1'b1;
      else begin
        if (stall_o) stalls++;
        @(negedge clk);
      end
    end
    chk("chg done", 32'(seen), 32'd1);
    chk("chg stalls", 32'(stalls), 32'd33);
    chk("chg result", md_result_o, 32'd14);
    chk("chg stall in DONE", 32'(stall_o), 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    chk("chg no relaunch", 32'(stall_o), 32'd0);
    chk("chg done pulse", 32'(md_done_o), 32'd0);

    // Reset at cycle 12 of a MUL.
    @(negedge clk);
    valid_i = 1'b1; funct7_i = 7'b0000001; ALU_Op_i = 3'b000; funct3_i = 3'b000;
    rs1_data_i = 32'd9; rs2_data_i = 32'd9;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre-reset stall", 32'(stall_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort stall", 32'(stall_o), 32'd0);
    chk("abort result", md_result_o, 32'd0);
    chk("abort done", 32'(md_done_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (md_done_o) done_seen = 1'b1;
    end
    chk("abort no done", 32'(done_seen), 32'd0);
    chk("abort idle", 32'(stall_o), 32'd0);

    run_md("MUL 6x7", 3'b000, 32'd6, 32'd7, 32'd42, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
